// File: rtl/pulse_decoder_3to8.sv
// Sequential 3:8 decoder: shows each accepted code as a one-hot pulse for
// HOLD_CYCLES cycles, with a GAP_CYCLES all-zero break and a one-entry pending buffer.
module pulse_decoder_3to8 #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] I,
    input  logic       abort,
    output logic [7:0] Y,
    output logic       y_valid,
    output logic [2:0] y_code,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

    function automatic logic [7:0] onehot(input logic [2:0] code);
        onehot = 8'b0000_0001 << code;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pend_full_q, pend_full_d;
    logic [2:0] pend_code_q, pend_code_d;
    logic [7:0] y_q, y_d;
    logic       y_valid_q, y_valid_d;
    logic [2:0] y_code_q, y_code_d;
    logic       accept_s;

    // Handshake: full buffer or a flush in progress blocks new codes.
    always_comb begin
        if (abort) begin
            in_ready = 1'b0;
        end else if (state_q == ST_IDLE) begin
            in_ready = 1'b1;
        end else begin
            in_ready = !pend_full_q;
        end
    end

    assign accept_s = in_valid && in_ready;

    // Next-state logic for the pulse sequencer and pending buffer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_full_d = pend_full_q;
        pend_code_d = pend_code_q;
        y_d         = y_q;
        y_valid_d   = y_valid_q;
        y_code_d    = y_code_q;

        if (abort) begin
            state_d     = ST_IDLE;
            cnt_d       = 8'd0;
            pend_full_d = 1'b0;
            pend_code_d = 3'd0;
            y_d         = 8'h00;
            y_valid_d   = 1'b0;
            y_code_d    = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_d   = ST_HOLD;
                        cnt_d     = HOLD_LOAD;
                        y_d       = onehot(I);
                        y_valid_d = 1'b1;
                        y_code_d  = I;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (accept_s) begin
                        pend_full_d = 1'b1;
                        pend_code_d = I;
                    end else begin
                        pend_full_d = pend_full_q;
                    end
                    if (cnt_q == 8'd0) begin
                        state_d   = ST_GAP;
                        cnt_d     = GAP_LOAD;
                        y_d       = 8'h00;
                        y_valid_d = 1'b0;
                        y_code_d  = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                ST_GAP: begin
                    // Pending code wins over a bypass; in_ready is low then anyway.
                    if (cnt_q == 8'd0) begin
                        if (pend_full_q) begin
                            state_d     = ST_HOLD;
                            cnt_d       = HOLD_LOAD;
                            y_d         = onehot(pend_code_q);
                            y_valid_d   = 1'b1;
                            y_code_d    = pend_code_q;
                            pend_full_d = 1'b0;
                        end else if (accept_s) begin
                            state_d   = ST_HOLD;
                            cnt_d     = HOLD_LOAD;
                            y_d       = onehot(I);
                            y_valid_d = 1'b1;
                            y_code_d  = I;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                        if (accept_s) begin
                            pend_full_d = 1'b1;
                            pend_code_d = I;
                        end else begin
                            pend_full_d = pend_full_q;
                        end
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    cnt_d       = 8'd0;
                    pend_full_d = 1'b0;
                    pend_code_d = 3'd0;
                    y_d         = 8'h00;
                    y_valid_d   = 1'b0;
                    y_code_d    = 3'd0;
                end
            endcase
        end
    end

    // State, counter, buffer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            pend_full_q <= 1'b0;
            pend_code_q <= 3'd0;
            y_q         <= 8'h00;
            y_valid_q   <= 1'b0;
            y_code_q    <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_full_q <= pend_full_d;
            pend_code_q <= pend_code_d;
            y_q         <= y_d;
            y_valid_q   <= y_valid_d;
            y_code_q    <= y_code_d;
        end
    end

    assign Y       = y_q;
    assign y_valid = y_valid_q;
    assign y_code  = y_code_q;
    assign busy    = (state_q != ST_IDLE) || pend_full_q;

endmodule

// File: doc/pulse_decoder_3to8.md
Name: pulse_decoder_3to8

Overview:
- Sequential 3:8 decoder, the inverse of the team's 8:3 priority encoder.
- Accepts 3-bit codes over a valid/ready handshake.
- Drives the matching one-hot line of an 8-bit output for a fixed number of cycles, then forces a break-before-make gap before the next code is shown.
- Has a one-entry pending buffer, so a producer (e.g. the priority encoder output path) can queue the next code while the current pulse is still active.

Parameters:
- HOLD_CYCLES, 4: cycles each one-hot pulse stays asserted. Legal range 1..255.
- GAP_CYCLES, 1: all-zero cycles between consecutive pulses. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  code on I is offered
- in_ready  output  1  block can accept a code this cycle
- I  input  3  encoded index 0..7
- abort  input  1  synchronous flush
- Y  output  8  registered one-hot output, Y[I] = 1
- y_valid  output  1  high while Y is non-zero (HOLD state)
- y_code  output  3  registered index currently driven on Y; 0 when idle
- busy  output  1  state is not IDLE, or the pending buffer is full

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs: Y=8'h00, y_valid=0, y_code=0, busy=0, in_ready=1.
  - Internal: state=IDLE, pending buffer empty, counter=0.
  - Release is synchronous to clk.
- Accept: a code is accepted on a rising edge where in_valid && in_ready.
- in_ready (combinational):
  - 1 in IDLE.
  - Otherwise equals !pend_full.
  - Forced 0 while abort=1.
- States: IDLE, HOLD, GAP.
- IDLE:
  - On accept: next cycle Y = 8'b1 << I, y_code = I, y_valid = 1, counter = HOLD_CYCLES-1, state goes to HOLD.
  - Latency from accept edge to Y valid: 1 clock.
- HOLD:
  - Y and y_code held constant.
  - An accept stores I into the pending buffer (pend_full=1).
  - Counter decrements each cycle.
  - At counter==0: next cycle Y=0, y_valid=0, y_code=0, counter=GAP_CYCLES-1, state goes to GAP.
  - Y is therefore non-zero for exactly HOLD_CYCLES cycles.
- GAP:
  - Y=0. An accept is still allowed into an empty pending buffer.
  - At counter==0, evaluated in this order:
    - pend_full: load the pending code into Y/y_code, go to HOLD, empty the buffer. The incoming code is not accepted, because in_ready=0.
    - Pending empty and an accept on this same edge: load I directly into HOLD (bypass). This has the same 1-cycle latency as IDLE.
    - Otherwise: go to IDLE.
- Consecutive pulses are separated by exactly GAP_CYCLES zero cycles. No cycle ever has two bits of Y set.
- abort:
  - Takes priority over all other events.
  - Next cycle: Y=0, y_valid=0, y_code=0, pending buffer cleared, state goes to IDLE.
  - Any code offered in the abort cycle is dropped (in_ready=0).
- busy = (state != IDLE) || pend_full.
- Counter width is 8 bits. No wrap-around occurs within the legal parameter range.
- Reset asserted mid-pulse clears everything immediately (asynchronously). No partial pulse resumes after release.

Test Plan:
- Reset then single code: I=3'd5, one-cycle in_valid.
  - Next cycle Y=8'b00100000, y_code=5.
  - Held 4 cycles, then Y=0 for 1 cycle, then IDLE with busy=0.
- Back-to-back: I=2 accepted, then I=6 offered during HOLD.
  - Y=8'b00000100 for 4 cycles, 1 zero cycle, then Y=8'b01000000 for 4 cycles.
  - in_ready=0 from the cycle after the I=6 accept until that code moves into HOLD.
- Full buffer: during HOLD with code 1, offer 3 then 7 on consecutive cycles.
  - 3 is accepted; 7 sees in_ready=0 and is held until after 3 loads.
  - Output sequence is 0x02, 0x08, 0x80 with single gap cycles between them.
- Bypass at end of GAP: offer I=0 exactly on the last GAP cycle with the buffer empty.
  - Next cycle Y=8'b00000001 with no extra idle cycle.
- Abort: abort=1 during the second HOLD cycle of code 4, with code 2 pending.
  - Next cycle Y=0, busy=0, in_ready=1.
  - Code 2 never appears on Y.
- Async reset mid-pulse: drop rst_n between clock edges during HOLD of code 7.
  - Y=0 and y_valid=0 immediately, without waiting for a clock edge.
  - After release, a new code 1 produces Y=8'b00000010 with 1-cycle latency.
